// File: rtl/chase_rate_ctrl.sv
// chase_rate_ctrl
// Front-end control stage for the 16-LED chasing display. Debounces the
// pause / faster / slower pushbuttons, keeps the run/pause state and the
// 3-bit speed level, and generates the step qualifier for the LED shifter.
//
// Debouncer FSM (one instance per button):
//   state        | meaning
//   IDLE         | button released and stable
//   WAIT_PRESS   | synchronized level high, counting stable samples
//   PRESSED      | press accepted; one-cycle button event
//   HELD         | button held, no further events
//   WAIT_RELEASE | synchronized level low, counting stable samples
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   btn_pause  in   raw pause button (active-high, asynchronous)
//   btn_faster in   raw speed-up button (active-high, asynchronous)
//   btn_slower in   raw slow-down button (active-high, asynchronous)
//   stop       out  0 = shifter advances this cycle
//   running    out  1 = chase running, 0 = paused
//   speed      out  speed level, 0 = slowest, 7 = fastest
module chase_rate_ctrl #(
    parameter int DB_CYCLES = 20000,
    parameter int BASE_DIV  = 390625
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_pause,
    input  logic       btn_faster,
    input  logic       btn_slower,
    output logic       stop,
    output logic       running,
    output logic [2:0] speed
);

    localparam int DW = $clog2(DB_CYCLES);
    localparam int PW = $clog2(BASE_DIV * 128);
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PRESS,
        PRESSED,
        HELD,
        WAIT_RELEASE
    } db_state_t;

    // bit 0 = pause, bit 1 = faster, bit 2 = slower
    logic [2:0] btn_raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] ev;

    assign btn_raw = {btn_slower, btn_faster, btn_pause};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_db
        db_state_t     state;
        logic [DW-1:0] dcnt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state <= IDLE;
                dcnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (sync2[i]) begin
                            state <= WAIT_PRESS;
                            dcnt  <= '0;
                        end
                    end
                    WAIT_PRESS: begin
                        if (!sync2[i])
                            state <= IDLE;
                        else if (dcnt == DB_LAST)
                            state <= PRESSED;
                        else
                            dcnt <= dcnt + DW'(1);
                    end
                    PRESSED: state <= HELD;
                    HELD: begin
                        if (!sync2[i]) begin
                            state <= WAIT_RELEASE;
                            dcnt  <= '0;
                        end
                    end
                    WAIT_RELEASE: begin
                        if (sync2[i])
                            state <= HELD;
                        else if (dcnt == DB_LAST)
                            state <= IDLE;
                        else
                            dcnt <= dcnt + DW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign ev[i] = (state == PRESSED);
    end

    logic          speed_up;
    logic          speed_dn;
    logic          pcnt_clr;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] period_m1;

    // Opposing speed events cancel; a saturated press changes nothing and
    // therefore must not restart the step period.
    assign speed_up = ev[1] & ~ev[2] & (speed != 3'd7);
    assign speed_dn = ev[2] & ~ev[1] & (speed != 3'd0);
    assign pcnt_clr = ev[0] | speed_up | speed_dn;

    // When BASE_DIV is a power of two the speed-0 period is exactly 2**PW and
    // wraps to zero here; the subtraction brings it back to the all-ones value.
    assign period_m1 = (PW'(BASE_DIV) << (3'd7 - speed)) - PW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            speed   <= 3'd3;
            pcnt    <= '0;
        end else begin
            if (ev[0])
                running <= ~running;

            if (speed_up)
                speed <= speed + 3'd1;
            else if (speed_dn)
                speed <= speed - 3'd1;

            if (pcnt_clr)
                pcnt <= '0;
            else if (running)
                pcnt <= (pcnt == period_m1) ? '0 : pcnt + PW'(1);
        end
    end

    // Decoded from current state only, so an event landing on a step cycle
    // does not suppress that step.
    assign stop = ~(running & (pcnt == period_m1));

endmodule

// File: tb/tb_chase_rate_ctrl.sv
module tb_chase_rate_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_pause = 1'b0;
    logic       btn_faster = 1'b0;
    logic       btn_slower = 1'b0;
    logic       stop;
    logic       running;
    logic [2:0] speed;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // expected {running, speed} after each state change, in order
    logic [3:0] exp_q[$];
    logic [3:0] prev_st;

    chase_rate_ctrl #(.DB_CYCLES(4), .BASE_DIV(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_pause  (btn_pause),
        .btn_faster (btn_faster),
        .btn_slower (btn_slower),
        .stop       (stop),
        .running    (running),
        .speed      (speed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: every change of {running, speed} outside reset must match the
    // next queued expectation.
    always @(negedge clk) begin
        logic [3:0] e;
        if (reset) begin
            prev_st = {running, speed};
        end else if ({running, speed} !== prev_st) begin
            prev_st = {running, speed};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_change actual=%h required=no_change", prev_st);
            end else begin
                e = exp_q.pop_front();
                check("sb_state", int'(prev_st), int'(e));
            end
        end
    end

    task automatic press(input logic p, input logic f, input logic s);
        @(negedge clk);
        btn_pause  = p;
        btn_faster = f;
        btn_slower = s;
        repeat (10) @(negedge clk);
        btn_pause  = 1'b0;
        btn_faster = 1'b0;
        btn_slower = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_low(output int ok);
        int n = 0;
        while (stop !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        ok = (stop === 1'b0) ? 1 : 0;
    endtask

    task automatic measure(output int per, output int wid_hi);
        int ok;
        int t0;
        per    = -1;
        wid_hi = 0;
        wait_low(ok);
        if (ok == 0) return;
        t0 = cyc;
        @(negedge clk);
        wid_hi = int'(stop);
        wait_low(ok);
        if (ok != 0) per = cyc - t0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, per, wid, ok, t0, lows;

        // Reset
        repeat (3) @(negedge clk);
        check("rst_stop", stop, 1);
        check("rst_running", running, 0);
        check("rst_speed", speed, 3);
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (stop !== 1'b1) lows++;
        end
        check("rst_hold_stop_lows", lows, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Start: clean pause press, running rises at E7
        exp_q.push_back({1'b1, 3'd3});
        @(negedge clk);
        btn_pause = 1'b1;
        fork
            begin
                repeat (20) @(negedge clk);
                btn_pause = 1'b0;
            end
        join_none
        @(posedge clk);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("start_e6_running", running, 0);
        @(negedge clk);
        check("start_e7_running", running, 1);
        k = 0;
        while (stop === 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("start_first_step_delay", k, 31);
        @(negedge clk);
        check("start_step_width", stop, 1);
        measure(per, wid);
        check("period_speed3", per, 32);
        check("width_speed3", wid, 1);
        repeat (10) @(negedge clk);

        // Bounce: pulses of 2 samples never reach the debounce count
        for (int i = 0; i < 15; i++) begin
            btn_pause = ~btn_pause;
            repeat (2) @(negedge clk);
        end
        btn_pause = 1'b0;
        repeat (12) @(negedge clk);
        check("bounce_running", running, 1);

        // Speed range up, saturating at 7
        for (int i = 4; i <= 7; i++) exp_q.push_back({1'b1, 3'(i)});
        for (int i = 0; i < 6; i++) press(1'b0, 1'b1, 1'b0);
        check("speed_max", speed, 7);
        measure(per, wid);
        check("period_speed7", per, 2);
        check("width_speed7", wid, 1);

        // Speed range down, saturating at 0
        for (int i = 6; i >= 0; i--) exp_q.push_back({1'b1, 3'(i)});
        for (int i = 0; i < 9; i++) press(1'b0, 1'b0, 1'b1);
        check("speed_min", speed, 0);
        measure(per, wid);
        check("period_speed0", per, 256);
        check("width_speed0", wid, 1);

        // Faster + slower together: no speed change, step phase undisturbed
        wait_low(ok);
        t0 = cyc;
        press(1'b0, 1'b1, 1'b1);
        wait_low(ok);
        check("fs_no_clear_interval", cyc - t0, 256);
        check("fs_speed", speed, 0);

        // Pause + faster together: both apply
        exp_q.push_back({1'b0, 3'd1});
        press(1'b1, 1'b1, 1'b0);
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (stop !== 1'b1) lows++;
        end
        check("paused_stop_lows", lows, 0);

        // Climb to speed 5 while paused, then resume
        for (int i = 2; i <= 5; i++) exp_q.push_back({1'b0, 3'(i)});
        for (int i = 0; i < 4; i++) press(1'b0, 1'b1, 1'b0);
        exp_q.push_back({1'b1, 3'd5});
        press(1'b1, 1'b0, 1'b0);
        check("resume_running", running, 1);

        // Reset mid-debounce with the pause button held through release
        @(negedge clk);
        btn_pause = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_running", running, 0);
        check("midrst_speed", speed, 3);
        check("midrst_stop", stop, 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_q.push_back({1'b1, 3'd3});
        @(posedge clk);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("midrst_e6_running", running, 0);
        @(negedge clk);
        check("midrst_e7_running", running, 1);
        btn_pause = 1'b0;
        repeat (15) @(negedge clk);

        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chase_rate_ctrl.md
# chase_rate_ctrl

Front-end control stage for the 16-LED chasing display. It debounces three pushbuttons (pause, faster, slower) and keeps a run/pause state and a 3-bit speed level. It produces the `stop` qualifier consumed by the LED shifter: `stop` is low for exactly one clock per step period while running, and high at all other times. The shifter therefore advances one position per period and freezes while paused.

## Interface

- `DB_CYCLES`, default 20000: consecutive stable synchronized samples required to accept a button level change; must be ≥ 2.
- `BASE_DIV`, default 390625: step period in clocks at speed level 7; must be ≥ 1.
- `clk`: in, 1 bit. Clock; all state updates on the rising edge.
- `reset`: in, 1 bit. Reset, asynchronous, active-high.
- `btn_pause`: in, 1 bit. Raw, asynchronous pause button, active-high.
- `btn_faster`: in, 1 bit. Raw, asynchronous speed-up button, active-high.
- `btn_slower`: in, 1 bit. Raw, asynchronous slow-down button, active-high.
- `stop`: out, 1 bit. To shifter; 0 = advance this cycle.
- `running`: out, 1 bit. 1 = chase running, 0 = paused.
- `speed`: out, 3 bits. Current speed level; 0 = slowest, 7 = fastest.

## Operation

- **Synchronizer.** Each button passes through a 2-FF synchronizer. The output is `s`.
- **Debouncer.** One FSM per button, with states IDLE, WAIT_PRESS, PRESSED, HELD and WAIT_RELEASE, and counter `dcnt` of width clog2(DB_CYCLES).
  - IDLE: if `s`=1, go to WAIT_PRESS with `dcnt`=0.
  - WAIT_PRESS: if `s`=0, go to IDLE. Otherwise, if `dcnt`==DB_CYCLES-1, go to PRESSED; else increment `dcnt`.
  - PRESSED: lasts one cycle. The button event is high for this cycle only. Then go to HELD.
  - HELD: if `s`=0, go to WAIT_RELEASE with `dcnt`=0.
  - WAIT_RELEASE: if `s`=1, go to HELD. Otherwise, if `dcnt`==DB_CYCLES-1, go to IDLE; else increment `dcnt`.
  - Exactly one event per accepted press. No auto-repeat while held.
- **Pause event.** `running` toggles and the period counter clears to 0.
- **Faster event.** `speed` increments and saturates at 7. **Slower event.** `speed` decrements and saturates at 0.
  - Faster and slower events in the same cycle: `speed` unchanged.
  - Any event that actually changes `speed` clears the period counter. A saturated press does not clear it.
- **Period.** P = BASE_DIV << (7 - `speed`), so P is BASE_DIV×128 at speed 0 and BASE_DIV at speed 7.
  - Counter `pcnt` has width clog2(BASE_DIV×128).
- **Counting.** While `running`=1:
  - If `pcnt`==P-1, `pcnt` wraps to 0; otherwise `pcnt` increments.
  - While `running`=0, `pcnt` holds its value.
- **stop output.** `stop` = ~(`running` & (`pcnt`==P-1)).
  - It is decoded only from registers, with no combinational path from the button inputs.
- **Simultaneous pause and speed events.** Both take effect and `pcnt` clears.
  - If a pause event arrives in a cycle where `stop`=0, that cycle's `stop` is still 0, because it is decoded from current state.

## Timing

- **Reset values** (asserted asynchronously, immediately): `running`=0, `speed`=3, `pcnt`=0, all debouncers IDLE with `dcnt`=0, synchronizers 0, `stop`=1.
- **Reset mid-operation** (including mid-debounce): all state returns to the reset values. A button held through reset release must complete a full DB_CYCLES debounce before it generates an event.
- **Button latency.** A raw button is first sampled high at edge E0.
  - `s`=1 after E1; WAIT_PRESS is entered at E2; PRESSED is entered at E2+DB_CYCLES.
  - `running` or `speed` updates at E3+DB_CYCLES.
- **Glitches.** A pulse shorter than DB_CYCLES synchronized samples produces no event.
- **Step rate.** While running at constant speed, `stop`=0 for exactly 1 cycle in every P cycles.
  - After a clear, the first `stop`=0 occurs P cycles after the clearing edge.

## Test plan

Sim parameters: DB_CYCLES=4, BASE_DIV=2.

- **Reset.** Assert `reset` -> `stop`=1, `running`=0, `speed`=3. Hold 100 cycles -> `stop` stays 1.
- **Start.** Clean pause press held 20 cycles -> `running`=1 at E7, exactly one toggle; `stop`=0 pulses every 32 cycles (P=2<<4), 1 cycle wide.
- **Bounce.** Pause input toggling every 2 cycles for 30 cycles, then low -> no event; `running` unchanged.
- **Speed range.** Press faster 6 times -> `speed` 4,5,6,7,7,7 and `stop` period 2 cycles. Press slower 9 times -> `speed` reaches 0 and period 256.
- **Simultaneous buttons.** Faster and slower pressed on identical cycles -> `speed` unchanged and `pcnt` not cleared. Pause plus faster together -> `running` toggles and `speed`+1.
- **Reset mid-operation.** Pulse `reset` while running at speed 5 with a pause press mid-debounce -> `speed`=3, `running`=0; the held button yields one event only after release of reset plus DB_CYCLES+3 cycles.
